// File: rtl/microc_pkg.sv
// microc_pkg
// Shared definitions for the microc instruction sequencer:
//   - state_t     : sequencer FSM states (IDLE, FETCH, EXEC, HALT)
//   - op_class_t  : decoded instruction class
//   - OP_*        : opcode prefixes / full opcodes for the control-flow classes
//   - decode_class: maps a 6-bit opcode onto its class
package microc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_J,
    CLS_JZ,
    CLS_JNZ,
    CLS_CALL,
    CLS_RET,
    CLS_NOP,
    CLS_HALT
  } op_class_t;

  // Branch classes are identified by their top four opcode bits; the low two
  // bits are free for the datapath and ignored here.
  localparam logic [3:0] OP_J   = 4'b1100;
  localparam logic [3:0] OP_JZ  = 4'b1101;
  localparam logic [3:0] OP_JNZ = 4'b1110;

  localparam logic [5:0] OP_CALL = 6'b111100;
  localparam logic [5:0] OP_RET  = 6'b111101;
  localparam logic [5:0] OP_NOP  = 6'b111110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Everything below 1100xx is an ALU operation that commits through exec_en.
  function automatic op_class_t decode_class(input logic [5:0] op);
    op_class_t cls;
    cls = CLS_ALU;
    if (op[5:2] == OP_J) begin
      cls = CLS_J;
    end else if (op[5:2] == OP_JZ) begin
      cls = CLS_JZ;
    end else if (op[5:2] == OP_JNZ) begin
      cls = CLS_JNZ;
    end else if (op == OP_CALL) begin
      cls = CLS_CALL;
    end else if (op == OP_RET) begin
      cls = CLS_RET;
    end else if (op == OP_NOP) begin
      cls = CLS_NOP;
    end else if (op == OP_HALT) begin
      cls = CLS_HALT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/return_stack.sv
// return_stack
// LIFO of return addresses for CALL/RET.
// Ports:
//   reloj  in   clock (rising edge)
//   reset  in   synchronous active-low reset, empties the stack
//   push   in   write din on top (ignored when full)
//   pop    in   discard the top entry (ignored when empty)
//   din    in   PC_W return address to push
//   dout   out  PC_W current top entry (meaningless while empty)
//   full   out  STACK_D entries held
//   empty  out  no entries held
module return_stack
#(
  parameter int PC_W    = 10,
  parameter int STACK_D = 4
)
(
  input  logic            reloj,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int CNT_W = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STACK_D);

  logic [PC_W-1:0]  mem [STACK_D];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // count is both the fill level and the index of the next free slot.
  assign wr_idx = IDX_W'(count);
  assign rd_idx = IDX_W'(count - CNT_ONE);
  assign full   = (count == CNT_MAX);
  assign empty  = (count == '0);
  assign dout   = mem[rd_idx];

  // Storage needs no reset: entries are only visible below count.
  always_ff @(posedge reloj) begin
    if (reset && push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  // Push has priority; the sequencer never requests both in one cycle.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/secuenciador_microc.sv
// secuenciador_microc
// Multi-cycle instruction sequencer for the microc CPU. Owns the PC, fetches
// through an imem req/ack handshake, holds the IR and resolves control flow.
// Ports:
//   reloj      in   clock (rising edge)
//   reset      in   synchronous active-low reset
//   run        in   start request, looked at only while idle
//   imem_ack   in   opcode/dest valid this cycle
//   opcode     in   6-bit instruction opcode
//   dest       in   PC_W branch/call target
//   zero       in   datapath zero flag, used by JZ/JNZ in EXEC
//   pc         out  PC_W current fetch address
//   imem_req   out  fetch request, high throughout FETCH
//   ir_we      out  IR load pulse on the accepted fetch cycle
//   exec_en    out  datapath commit enable, EXEC of ALU instructions only
//   busy       out  high in FETCH and EXEC
//   halted     out  high in HALT
//   stack_err  out  sticky return stack overflow/underflow
module secuenciador_microc
  import microc_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int STACK_D = 4
)
(
  input  logic            reloj,
  input  logic            reset,
  input  logic            run,
  input  logic            imem_ack,
  input  logic [5:0]      opcode,
  input  logic [PC_W-1:0] dest,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic            ir_we,
  output logic            exec_en,
  output logic            busy,
  output logic            halted,
  output logic            stack_err
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state;
  logic [5:0]      ir_op;
  logic [PC_W-1:0] ir_dest;
  op_class_t       exec_cls;
  logic [PC_W-1:0] pc_inc;

  logic            stack_push;
  logic            stack_pop;
  logic [PC_W-1:0] stack_top;
  logic            stack_full;
  logic            stack_empty;

  assign exec_cls = decode_class(ir_op);
  // Natural PC_W-bit overflow gives the 2^PC_W-1 -> 0 wrap, also for the
  // return address pushed by CALL.
  assign pc_inc   = pc + PC_ONE;

  // The load pulse follows the ack directly, since the memory only presents
  // the instruction during that cycle. Gated by reset so a fetch that is
  // being aborted never reaches the IR.
  assign ir_we = (state == FETCH) && imem_ack && reset;

  assign stack_push = (state == EXEC) && (exec_cls == CLS_CALL) && !stack_full;
  assign stack_pop  = (state == EXEC) && (exec_cls == CLS_RET) && !stack_empty;

  return_stack #(
    .PC_W    (PC_W),
    .STACK_D (STACK_D)
  ) u_return_stack (
    .reloj (reloj),
    .reset (reset),
    .push  (stack_push),
    .pop   (stack_pop),
    .din   (pc_inc),
    .dout  (stack_top),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Sequencer FSM. Status outputs are registered alongside the state so each
  // one changes on exactly the edge that enters or leaves its state. exec_en
  // is decided from the incoming opcode when the fetch is accepted, which
  // makes it high for the single EXEC cycle that follows.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= '0;
      ir_op     <= '0;
      ir_dest   <= '0;
      imem_req  <= 1'b0;
      exec_en   <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      exec_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir_op    <= opcode;
            ir_dest  <= dest;
            state    <= EXEC;
            imem_req <= 1'b0;
            exec_en  <= (decode_class(opcode) == CLS_ALU);
          end
        end
        EXEC: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          case (exec_cls)
            CLS_ALU, CLS_NOP: pc <= pc_inc;
            CLS_J:            pc <= ir_dest;
            CLS_JZ:           pc <= zero ? ir_dest : pc_inc;
            CLS_JNZ:          pc <= zero ? pc_inc : ir_dest;
            CLS_CALL: begin
              if (stack_full) begin
                stack_err <= 1'b1;
                state     <= HALT;
                imem_req  <= 1'b0;
                busy      <= 1'b0;
                halted    <= 1'b1;
              end else begin
                pc <= ir_dest;
              end
            end
            CLS_RET: begin
              if (stack_empty) begin
                stack_err <= 1'b1;
                state     <= HALT;
                imem_req  <= 1'b0;
                busy      <= 1'b0;
                halted    <= 1'b1;
              end else begin
                pc <= stack_top;
              end
            end
            CLS_HALT: begin
              state    <= HALT;
              imem_req <= 1'b0;
              busy     <= 1'b0;
              halted   <= 1'b1;
            end
            default: begin
              state <= FETCH;
            end
          endcase
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_microc.sv
// tb_secuenciador_microc
// Self-checking bench for secuenciador_microc: a directed vector table, hand
// sequences for the multi-cycle corners and a randomized run, all compared
// against an instruction-level reference model kept in this file.
module tb_secuenciador_microc;

  localparam int PC_W    = 10;
  localparam int STACK_D = 4;
  localparam int PC_MOD  = 1 << PC_W;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_STOP  = 3;

  localparam int K_ALU  = 0;
  localparam int K_J    = 1;
  localparam int K_JZ   = 2;
  localparam int K_JNZ  = 3;
  localparam int K_CALL = 4;
  localparam int K_RET  = 5;
  localparam int K_NOP  = 6;
  localparam int K_HALT = 7;

  localparam int ALU = 6'h05;
  localparam int JMP = 6'h30;
  localparam int JZ  = 6'h34;
  localparam int JNZ = 6'h38;
  localparam int CAL = 6'h3C;
  localparam int RET = 6'h3D;
  localparam int HLT = 6'h3F;

  logic            reloj;
  logic            reset;
  logic            run;
  logic            imem_ack;
  logic [5:0]      opcode;
  logic [PC_W-1:0] dest;
  logic            zero;
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic            ir_we;
  logic            exec_en;
  logic            busy;
  logic            halted;
  logic            stack_err;

  secuenciador_microc #(
    .PC_W    (PC_W),
    .STACK_D (STACK_D)
  ) dut (
    .reloj     (reloj),
    .reset     (reset),
    .run       (run),
    .imem_ack  (imem_ack),
    .opcode    (opcode),
    .dest      (dest),
    .zero      (zero),
    .pc        (pc),
    .imem_req  (imem_req),
    .ir_we     (ir_we),
    .exec_en   (exec_en),
    .busy      (busy),
    .halted    (halted),
    .stack_err (stack_err)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  int checks = 0;
  int errors = 0;

  // Reference model: where the sequencer is, the architectural PC, the
  // instruction in flight and a queue standing in for the return stack.
  int m_mode = M_IDLE;
  int m_pc   = 0;
  int m_op   = 0;
  int m_dest = 0;
  bit m_err  = 1'b0;
  int m_stack[$];
  bit last_irwe = 1'b0;

  typedef struct {
    bit rst;
    bit run;
    bit ack;
    int op;
    int dst;
    bit zero;
    bit irwe;
    int pc;
    bit req;
    bit ex;
    bit busy;
    bit halt;
    bit err;
  } vec_t;

  vec_t vecs[$];

  function automatic int op_kind(input int op);
    if (op < 48) return K_ALU;
    if (op < 52) return K_J;
    if (op < 56) return K_JZ;
    if (op < 60) return K_JNZ;
    if (op == 60) return K_CALL;
    if (op == 61) return K_RET;
    if (op == 62) return K_NOP;
    return K_HALT;
  endfunction

  task automatic model_step(input bit r, input bit run_i, input bit ack_i,
                            input int op_i, input int dest_i, input bit zero_i);
    int nxt;
    if (!r) begin
      m_mode = M_IDLE;
      m_pc   = 0;
      m_op   = 0;
      m_dest = 0;
      m_err  = 1'b0;
      m_stack.delete();
      return;
    end
    case (m_mode)
      M_IDLE: if (run_i) m_mode = M_FETCH;
      M_FETCH: begin
        if (ack_i) begin
          m_op   = op_i;
          m_dest = dest_i;
          m_mode = M_EXEC;
        end
      end
      M_EXEC: begin
        nxt    = (m_pc + 1) % PC_MOD;
        m_mode = M_FETCH;
        case (op_kind(m_op))
          K_ALU, K_NOP: m_pc = nxt;
          K_J:          m_pc = m_dest;
          K_JZ:         m_pc = zero_i ? m_dest : nxt;
          K_JNZ:        m_pc = zero_i ? nxt : m_dest;
          K_CALL: begin
            if (m_stack.size() >= STACK_D) begin
              m_err  = 1'b1;
              m_mode = M_STOP;
            end else begin
              m_stack.push_back(nxt);
              m_pc = m_dest;
            end
          end
          K_RET: begin
            if (m_stack.size() == 0) begin
              m_err  = 1'b1;
              m_mode = M_STOP;
            end else begin
              m_pc = m_stack.pop_back();
            end
          end
          default: m_mode = M_STOP;
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic check_bit(input string name, input logic got, input bit exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_pc(input string name, input logic [PC_W-1:0] got, input int exp);
    checks++;
    if (got !== PC_W'(exp)) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, PC_W'(exp));
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input bit irwe_got, input bit irwe_exp,
                             input int pc_exp, input bit req_exp, input bit ex_exp,
                             input bit busy_exp, input bit halt_exp, input bit err_exp);
    check_bit($sformatf("%s.ir_we", name), irwe_got, irwe_exp);
    check_pc($sformatf("%s.pc", name), pc, pc_exp);
    check_bit($sformatf("%s.imem_req", name), imem_req, req_exp);
    check_bit($sformatf("%s.exec_en", name), exec_en, ex_exp);
    check_bit($sformatf("%s.busy", name), busy, busy_exp);
    check_bit($sformatf("%s.halted", name), halted, halt_exp);
    check_bit($sformatf("%s.stack_err", name), stack_err, err_exp);
  endtask

  // Drives one cycle from a falling edge: ir_we is sampled just after the
  // inputs settle, registered outputs at the next falling edge.
  task automatic drive_cycle(input bit r, input bit run_i, input bit ack_i,
                             input int op_i, input int dest_i, input bit zero_i,
                             output bit irwe_seen);
    reset    = r;
    run      = run_i;
    imem_ack = ack_i;
    opcode   = 6'(op_i);
    dest     = PC_W'(dest_i);
    zero     = zero_i;
    #1;
    irwe_seen = ir_we;
    @(posedge reloj);
    @(negedge reloj);
  endtask

  task automatic applyStimulus(input string name, input bit r, input bit run_i, input bit ack_i,
                               input int op_i, input int dest_i, input bit zero_i);
    bit irwe_seen;
    bit irwe_exp;
    irwe_exp = (m_mode == M_FETCH) && ack_i && r;
    drive_cycle(r, run_i, ack_i, op_i, dest_i, zero_i, irwe_seen);
    last_irwe = irwe_seen;
    model_step(r, run_i, ack_i, op_i, dest_i, zero_i);
    checkOutput(name, irwe_seen, irwe_exp, m_pc, m_mode == M_FETCH,
                (m_mode == M_EXEC) && (op_kind(m_op) == K_ALU),
                (m_mode == M_FETCH) || (m_mode == M_EXEC), m_mode == M_STOP, m_err);
  endtask

  // One accepted fetch followed by its EXEC cycle.
  task automatic exec_instr(input string name, input int op_i, input int dest_i, input bit zero_i);
    applyStimulus(name, 1'b1, 1'b0, 1'b1, op_i, dest_i, 1'b0);
    applyStimulus(name, 1'b1, 1'b0, 1'b0, 0, 0, zero_i);
  endtask

  initial begin
    bit irwe_seen;
    int req_cycles;
    int irwe_count;
    int hold_pc;

    reset    = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    opcode   = '0;
    dest     = '0;
    zero     = 1'b0;

    // rst run ack op dst zero | irwe pc req ex busy halt err
    vecs.push_back('{0, 0, 0, ALU, 0,     0, 0, 0,     0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, ALU, 0,     0, 0, 0,     0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, ALU, 0,     0, 0, 0,     1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, ALU, 0,     0, 1, 0,     0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 0, ALU, 0,     0, 0, 1,     1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, ALU, 0,     0, 1, 1,     0, 1, 1, 0, 0});
    vecs.push_back('{1, 1, 0, ALU, 0,     0, 0, 2,     1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, ALU, 0,     0, 1, 2,     0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 0, ALU, 0,     0, 0, 3,     1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, JZ,  'h2A,  0, 1, 3,     0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 0, ALU, 0,     1, 0, 'h2A,  1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, JZ,  'h2A,  1, 1, 'h2A,  0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, HLT, 'h3FF, 0, 0, 'h2B,  1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, JNZ, 'h10,  0, 1, 'h2B,  0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, HLT, 0,     1, 0, 'h2C,  1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, JNZ, 'h10,  1, 1, 'h2C,  0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 0, ALU, 0,     0, 0, 'h10,  1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, JMP, 'h3FF, 1, 1, 'h10,  0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 0, ALU, 0,     0, 0, 'h3FF, 1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, ALU, 0,     0, 1, 'h3FF, 0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 0, ALU, 0,     0, 0, 0,     1, 0, 1, 0, 0});

    @(negedge reloj);

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, vecs[i].run, vecs[i].ack, vecs[i].op, vecs[i].dst,
                  vecs[i].zero, irwe_seen);
      model_step(vecs[i].rst, vecs[i].run, vecs[i].ack, vecs[i].op, vecs[i].dst, vecs[i].zero);
      checkOutput($sformatf("vec%0d", i), irwe_seen, vecs[i].irwe, vecs[i].pc, vecs[i].req,
                  vecs[i].ex, vecs[i].busy, vecs[i].halt, vecs[i].err);
    end

    $display("[TB] delayed acknowledge");
    req_cycles = 0;
    irwe_count = 0;
    hold_pc    = m_pc;
    for (int k = 0; k < 4; k++) begin
      if (imem_req === 1'b1) req_cycles++;
      check_pc("t2.pc_stable", pc, hold_pc);
      applyStimulus("t2", 1'b1, 1'b0, k == 3, ALU, 0, 1'b0);
      if (last_irwe) irwe_count++;
    end
    check_val("t2.req_cycles", req_cycles, 4);
    check_val("t2.ir_we_pulses", irwe_count, 1);
    applyStimulus("t2.exec", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("[TB] pc wrap and call/return across the wrap");
    exec_instr("t4.j", JMP, 'h3FF, 1'b0);
    check_pc("t4.at_top", pc, 'h3FF);
    exec_instr("t4.call", CAL, 'h10, 1'b0);
    check_pc("t4.in_sub", pc, 'h10);
    exec_instr("t4.ret", RET, 0, 1'b0);
    check_pc("t4.returned", pc, 0);

    $display("[TB] stack overflow and underflow");
    exec_instr("t5.c1", CAL, 'h05, 1'b0);
    exec_instr("t5.c2", CAL, 'h09, 1'b0);
    exec_instr("t5.c3", CAL, 'h20, 1'b0);
    exec_instr("t5.c4", CAL, 'h30, 1'b0);
    exec_instr("t5.c5", CAL, 'h40, 1'b0);
    check_pc("t5.ovf_pc", pc, 'h30);
    check_bit("t5.ovf_err", stack_err, 1'b1);
    check_bit("t5.ovf_halted", halted, 1'b1);
    applyStimulus("t5.rst", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus("t5.run", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    exec_instr("t5.alu", ALU, 0, 1'b0);
    exec_instr("t5.ret", RET, 'h55, 1'b0);
    check_pc("t5.unf_pc", pc, 1);
    check_bit("t5.unf_err", stack_err, 1'b1);
    check_bit("t5.unf_halted", halted, 1'b1);

    $display("[TB] halt opcode and reset during fetch");
    applyStimulus("t6.rst", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus("t6.run", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    exec_instr("t6.a1", ALU, 0, 1'b0);
    exec_instr("t6.a2", ALU, 0, 1'b0);
    exec_instr("t6.halt", HLT, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus("t6.parked", 1'b1, k[0], 1'b1, ALU, 0, 1'b0);
      check_bit("t6.halted_held", halted, 1'b1);
      check_bit("t6.req_low", imem_req, 1'b0);
    end
    check_pc("t6.halt_pc", pc, 2);
    check_bit("t6.halt_no_err", stack_err, 1'b0);
    applyStimulus("t6.rst2", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus("t6.run2", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    exec_instr("t6.a3", ALU, 0, 1'b0);
    check_bit("t6.fetching", imem_req, 1'b1);
    applyStimulus("t6.rst_mid", 1'b0, 1'b1, 1'b1, ALU, 0, 1'b0);
    check_pc("t6.rst_pc", pc, 0);
    check_bit("t6.rst_req", imem_req, 1'b0);
    check_bit("t6.rst_busy", busy, 1'b0);
    applyStimulus("t6.idle", 1'b1, 1'b0, 1'b1, ALU, 0, 1'b0);

    $display("[TB] randomized run");
    for (int i = 0; i < 800; i++) begin
      bit r;
      int sel;
      int op;
      r = ($urandom_range(0, 99) != 0);
      if (m_mode == M_STOP && $urandom_range(0, 3) == 0) r = 1'b0;
      sel = $urandom_range(0, 15);
      if (sel < 6)        op = $urandom_range(0, 47);
      else if (sel == 6)  op = 48 + $urandom_range(0, 3);
      else if (sel == 7)  op = 52 + $urandom_range(0, 3);
      else if (sel == 8)  op = 56 + $urandom_range(0, 3);
      else if (sel < 11)  op = CAL;
      else if (sel < 13)  op = RET;
      else if (sel < 15)  op = 62;
      else                op = HLT;
      applyStimulus($sformatf("rnd%0d", i), r, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) != 0), op, $urandom_range(0, PC_MOD - 1),
                    1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
